mskrnd_lfsr_feeder: RTL and testbench

MSKRND_LFSR_FEEDER -- requirements
Module: mskrnd_lfsr_feeder

---
 rtl/mskrnd_lfsr_feeder.sv | 153 +++++++++++++++
 tb/tb_mskrnd_lfsr_feeder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mskrnd_lfsr_feeder.sv
// mskrnd_lfsr_feeder: 64-bit LFSR that supplies fresh randomness to NGADGETS HPC2 gadgets.
// Defining MSKRND_DELIVERY_CNT_EN adds the rnd_cnt delivery counter output.
module mskrnd_lfsr_feeder #(
    parameter  int d        = 2,
    parameter  int NGADGETS = 4,
    parameter  int WARMUP   = 64,
    localparam int RND_W    = NGADGETS * d * (d - 1) / 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      seed_in,
    input  logic             seed_valid,
    output logic             seed_ready,
    input  logic             rnd_next,
    output logic [RND_W-1:0] rnd,
    output logic             rnd_valid
`ifdef MSKRND_DELIVERY_CNT_EN
    ,
    output logic [31:0]      rnd_cnt
`endif
);

    localparam int                CNT_W     = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic [CNT_W-1:0]  WARM_LAST = CNT_W'(WARMUP);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    generate
        if (RND_W < 1 || RND_W > 64) begin : g_bad_rnd_w
            $error("mskrnd_lfsr_feeder: RND_W must be within 1..64");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, LOAD1, WARM, RUN} state_t;

    state_t            state_r;
    logic [63:0]       s_r;
    logic [CNT_W-1:0]  warm_cnt_r;
    logic [RND_W-1:0]  rnd_r;
    logic              rnd_valid_r;
    logic              seed_ready_r;
    logic [63:0]       seed_full_s;
    logic [63:0]       seed_fix_s;
    logic [63:0]       s_adv_s;

    // RND_W unrolled LFSR steps, one advance per clock
    function automatic logic [63:0] lfsr_advance(input logic [63:0] s);
        logic [63:0] t;
        t = s;
        for (int i = 0; i < RND_W; i++) begin
            t = {t[62:0], t[63] ^ t[62] ^ t[60] ^ t[59]};
        end
        return t;
    endfunction

    // Seed assembly (an all-zero seed would lock the LFSR) and next advanced state
    always_comb begin
        seed_full_s = {s_r[63:32], seed_in};
        if (seed_full_s == 64'h0) begin
            seed_fix_s = 64'h1;
        end else begin
            seed_fix_s = seed_full_s;
        end
        s_adv_s = lfsr_advance(s_r);
    end

    // Seeding / warm-up / delivery FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            s_r          <= 64'h1;
            warm_cnt_r   <= {CNT_W{1'b0}};
            rnd_r        <= {RND_W{1'b0}};
            rnd_valid_r  <= 1'b0;
            seed_ready_r <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (seed_valid) begin
                        s_r[63:32] <= seed_in;
                        state_r    <= LOAD1;
                    end
                end
                LOAD1: begin
                    if (seed_valid) begin
                        s_r        <= seed_fix_s;
                        warm_cnt_r <= {CNT_W{1'b0}};
                        if (WARMUP == 0) begin
                            state_r     <= RUN;
                            rnd_r       <= seed_fix_s[RND_W-1:0];
                            rnd_valid_r <= 1'b1;
                        end else begin
                            state_r      <= WARM;
                            seed_ready_r <= 1'b0;
                        end
                    end
                end
                WARM: begin
                    if (warm_cnt_r == WARM_LAST) begin
                        state_r      <= RUN;
                        rnd_r        <= s_r[RND_W-1:0];
                        rnd_valid_r  <= 1'b1;
                        seed_ready_r <= 1'b1;
                    end else begin
                        s_r        <= s_adv_s;
                        warm_cnt_r <= warm_cnt_r + CNT_ONE;
                    end
                end
                RUN: begin
                    // A reseed wins over rnd_next so no value is consumed in that cycle
                    if (seed_valid) begin
                        s_r[63:32]  <= seed_in;
                        state_r     <= LOAD1;
                        rnd_r       <= {RND_W{1'b0}};
                        rnd_valid_r <= 1'b0;
                    end else if (rnd_next) begin
                        s_r   <= s_adv_s;
                        rnd_r <= s_adv_s[RND_W-1:0];
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    s_r          <= 64'h1;
                    warm_cnt_r   <= {CNT_W{1'b0}};
                    rnd_r        <= {RND_W{1'b0}};
                    rnd_valid_r  <= 1'b0;
                    seed_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign seed_ready = seed_ready_r;
    assign rnd        = rnd_r;
    assign rnd_valid  = rnd_valid_r;

`ifdef MSKRND_DELIVERY_CNT_EN
    logic [31:0] rnd_cnt_r;

    // Delivered-value counter, cleared by every accepted first seed word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd_cnt_r <= 32'h0;
        end else if (seed_valid && (state_r == IDLE || state_r == RUN)) begin
            rnd_cnt_r <= 32'h0;
        end else if (state_r == RUN && rnd_next) begin
            rnd_cnt_r <= rnd_cnt_r + 32'h1;
        end
    end

    assign rnd_cnt = rnd_cnt_r;
`endif

endmodule

// File: tb/tb_mskrnd_lfsr_feeder.sv
// Directed self-checking bench for mskrnd_lfsr_feeder (WARMUP=64 and WARMUP=0 instances).
module tb_mskrnd_lfsr_feeder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] seed_in, z_seed_in;
    logic        seed_valid, z_seed_valid;
    logic        rnd_next, z_rnd_next;
    logic        seed_ready, z_seed_ready;
    logic        rnd_valid, z_rnd_valid;
    logic [3:0]  rnd, z_rnd;
`ifdef MSKRND_DELIVERY_CNT_EN
    logic [31:0] rnd_cnt, z_rnd_cnt;
`endif

    int          n_total = 0;
    int          n_bad   = 0;
    logic [63:0] m, m_old;
    int          cnt;

    always #5 clk = ~clk;

    mskrnd_lfsr_feeder #(.d(2), .NGADGETS(4), .WARMUP(64)) dut (
        .clk(clk), .rst_n(rst_n), .seed_in(seed_in), .seed_valid(seed_valid),
        .seed_ready(seed_ready), .rnd_next(rnd_next), .rnd(rnd), .rnd_valid(rnd_valid)
`ifdef MSKRND_DELIVERY_CNT_EN
        , .rnd_cnt(rnd_cnt)
`endif
    );

    mskrnd_lfsr_feeder #(.d(2), .NGADGETS(4), .WARMUP(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .seed_in(z_seed_in), .seed_valid(z_seed_valid),
        .seed_ready(z_seed_ready), .rnd_next(z_rnd_next), .rnd(z_rnd), .rnd_valid(z_rnd_valid)
`ifdef MSKRND_DELIVERY_CNT_EN
        , .rnd_cnt(z_rnd_cnt)
`endif
    );

    function automatic logic [63:0] adv4(input logic [63:0] s);
        logic [63:0] t;
        t = s;
        for (int i = 0; i < 4; i++) t = {t[62:0], t[63] ^ t[62] ^ t[60] ^ t[59]};
        return t;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid;
        cnt = 0;
        while (!rnd_valid && cnt < 200) begin
            tick();
            cnt++;
            if (cnt == 10) rnd_next = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        seed_in = 32'h0; seed_valid = 1'b0; rnd_next = 1'b0;
        z_seed_in = 32'h0; z_seed_valid = 1'b0; z_rnd_next = 1'b0;
        #12;
        check_eq("rst_rnd", rnd, 4'h0);
        check_eq("rst_valid", rnd_valid, 1'b0);
        check_eq("rst_ready", seed_ready, 1'b1);
        #10 rst_n = 1'b1;
        tick();
        check_eq("post_rst_valid", rnd_valid, 1'b0);
        check_eq("post_rst_ready", seed_ready, 1'b1);

        // zero seed with no warm-up
        z_seed_valid = 1'b1; z_seed_in = 32'h0;
        tick();
        check_eq("z_load1_valid", z_rnd_valid, 1'b0);
        check_eq("z_load1_ready", z_seed_ready, 1'b1);
        tick();
        z_seed_valid = 1'b0;
        check_eq("z_run_valid", z_rnd_valid, 1'b1);
        check_eq("z_run_rnd", z_rnd, 4'h1);
        z_rnd_next = 1'b1;
        tick();
        z_rnd_next = 1'b0;
        check_eq("z_adv_rnd", z_rnd, 4'h0);
        check_eq("z_adv_s", dut_z.s_r, 64'h10);
`ifdef MSKRND_DELIVERY_CNT_EN
        check_eq("cnt_1", z_rnd_cnt, 32'd1);
        z_rnd_next = 1'b1;
        repeat (4) tick();
        z_rnd_next = 1'b0;
        check_eq("cnt_5", z_rnd_cnt, 32'd5);
        z_seed_valid = 1'b1; z_seed_in = 32'h1;
        tick();
        z_seed_valid = 1'b0;
        check_eq("cnt_reseed", z_rnd_cnt, 32'd0);
        check_eq("z_reseed_valid", z_rnd_valid, 1'b0);
`endif

        // seeded warm-up; rnd_next pulses during WARM must be ignored
        seed_valid = 1'b1; seed_in = 32'hDEADBEEF;
        tick();
        seed_in = 32'h01234567;
        tick();
        seed_valid = 1'b0;
        check_eq("warm_ready", seed_ready, 1'b0);
        check_eq("warm_valid", rnd_valid, 1'b0);
        m = 64'hDEADBEEF_01234567;
        repeat (64) m = adv4(m);
        rnd_next = 1'b1;
        wait_valid();
        rnd_next = 1'b0;
        check_eq("warm_latency", cnt, 65);
        check_eq("warm_rnd", rnd, m[3:0]);
        check_eq("run_ready", seed_ready, 1'b1);

        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("hold_rnd", rnd, m[3:0]);
        end

        rnd_next = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            m = adv4(m);
            check_eq("run_rnd", {rnd_valid, rnd}, {1'b1, m[3:0]});
        end
        rnd_next = 1'b0;

        // reseed with simultaneous rnd_next: no advance
        m_old = m;
        seed_valid = 1'b1; seed_in = 32'hCAFEF00D; rnd_next = 1'b1;
        tick();
        seed_valid = 1'b0; rnd_next = 1'b0;
        check_eq("reseed_valid", rnd_valid, 1'b0);
        check_eq("reseed_rnd", rnd, 4'h0);
        check_eq("reseed_s", dut.s_r, {32'hCAFEF00D, m_old[31:0]});
        repeat (3) tick();
        check_eq("load1_rnd", {rnd_valid, rnd}, 5'h00);
        seed_valid = 1'b1; seed_in = 32'h13579BDF;
        tick();
        seed_valid = 1'b0;
        m = 64'hCAFEF00D_13579BDF;
        repeat (64) m = adv4(m);
        wait_valid();
        check_eq("reseed_latency", cnt, 65);
        check_eq("reseed_rnd_run", rnd, m[3:0]);
        rnd_next = 1'b1;
        tick();
        rnd_next = 1'b0;
        m = adv4(m);
        check_eq("reseed_adv", rnd, m[3:0]);

        // reset during WARM discards the seed
        seed_valid = 1'b1; seed_in = 32'h11111111;
        tick();
        seed_in = 32'h22222222;
        tick();
        seed_valid = 1'b0;
        repeat (5) tick();
        check_eq("mid_warm_ready", seed_ready, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_rnd", rnd, 4'h0);
        check_eq("arst_valid", rnd_valid, 1'b0);
        check_eq("arst_ready", seed_ready, 1'b1);
        #2 rst_n = 1'b1;
        tick();
        check_eq("rel_rnd", rnd, 4'h0);
        check_eq("rel_valid", rnd_valid, 1'b0);
        check_eq("rel_ready", seed_ready, 1'b1);
        seed_valid = 1'b1; seed_in = 32'h33333333;
        tick();
        seed_valid = 1'b0;
        repeat (100) tick();
        check_eq("one_word_valid", rnd_valid, 1'b0);
        check_eq("one_word_ready", seed_ready, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
